// File: rtl/gmii_arb_pkg.sv
// Shared definitions for the GMII frame arbiters: FSM state encoding and
// the index-width helper used for grant, pointer and counter sizing.
package gmii_arb_pkg;

  typedef enum logic [1:0] {
    S_ARB  = 2'd0,
    S_XFER = 2'd1,
    S_GAP  = 2'd2
  } arb_state_e;

  // Width needed to hold values 0..n-1, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gmii_rr_pick.sv
// Round-robin picker: finds the first set request strictly after the pointer,
// wrapping around so the pointer position itself is considered last.
module gmii_rr_pick
  import gmii_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  int pos;

  // Scan from the farthest offset down so the nearest request wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    pos     = 0;
    for (int k = N; k >= 1; k--) begin
      pos = int'(ptr_i) + k;
      if (pos >= N) pos = pos - N;
      if (req_i[IW'(pos)]) begin
        found_o = 1'b1;
        idx_o   = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/gmii_wrr_arb.sv
// Weighted round-robin GMII frame arbiter: grants whole frames, up to the
// input's weight in a row, with a fixed idle gap after every frame.
module gmii_wrr_arb
  import gmii_arb_pkg::*;
#(
  parameter  int NUM_INPUTS     = 4,
  parameter  int INTERFRAME_GAP = 12,
  parameter  int WEIGHT_WIDTH   = 4,
  localparam int IW             = idx_w(NUM_INPUTS)
) (
  input  logic                               Clk,
  input  logic                               Rst_n,
  input  logic [NUM_INPUTS*8-1:0]            Input_data,
  input  logic [NUM_INPUTS-1:0]              Input_valid,
  input  logic [NUM_INPUTS-1:0]              Input_last,
  output logic [NUM_INPUTS-1:0]              Input_ready,
  input  logic [NUM_INPUTS*WEIGHT_WIDTH-1:0] Input_weight,
  output logic [7:0]                         Output_data,
  output logic                               Output_valid,
  output logic                               Output_last,
  input  logic                               Output_ready,
  output logic [IW-1:0]                      Grant_index
);

  localparam int             GW       = idx_w(INTERFRAME_GAP + 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'((INTERFRAME_GAP > 0) ? INTERFRAME_GAP - 1 : 0);
  localparam logic [IW-1:0]  PTR_RST  = IW'(NUM_INPUTS - 1);

  arb_state_e              state_q, state_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [IW-1:0]           grant_q, grant_d;
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;
  logic [GW-1:0]           gap_q, gap_d;

  logic [7:0]              data_a   [NUM_INPUTS];
  logic [WEIGHT_WIDTH-1:0] weight_a [NUM_INPUTS];
  logic [NUM_INPUTS-1:0]   req;
  logic                    pick_found;
  logic [IW-1:0]           pick_idx;
  logic                    cont_burst;
  logic                    last_beat;

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_unpack
    assign data_a[g]   = Input_data[g*8 +: 8];
    assign weight_a[g] = Input_weight[g*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    assign req[g]      = Input_valid[g] && (weight_a[g] != '0);
  end

  gmii_rr_pick #(.N(NUM_INPUTS)) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // A burst continues only while credit remains and the owner is still enabled.
  assign cont_burst = (credit_q != '0) && Input_valid[grant_q] && (weight_a[grant_q] != '0);
  assign last_beat  = (state_q == S_XFER) && Input_valid[grant_q] && Output_ready
                      && Input_last[grant_q];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= S_ARB;
      ptr_q    <= PTR_RST;
      grant_q  <= '0;
      credit_q <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      credit_q <= credit_d;
      gap_q    <= gap_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    credit_d = credit_q;
    gap_d    = gap_q;
    unique case (state_q)
      S_ARB: begin
        if (cont_burst) begin
          state_d = S_XFER;
        end else if (pick_found) begin
          grant_d  = pick_idx;
          ptr_d    = pick_idx;
          credit_d = weight_a[pick_idx];
          state_d  = S_XFER;
        end
      end
      S_XFER: begin
        if (last_beat) begin
          credit_d = (credit_q != '0) ? credit_q - 1'b1 : '0;
          gap_d    = '0;
          state_d  = (INTERFRAME_GAP == 0) ? S_ARB : S_GAP;
        end
      end
      S_GAP: begin
        // The gap runs on wall-clock cycles, independent of Output_ready.
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_ARB;
        end
      end
      default: state_d = S_ARB;
    endcase
  end

  always_comb begin
    Output_data  = data_a[grant_q];
    Output_last  = Input_last[grant_q];
    Output_valid = 1'b0;
    Input_ready  = '0;
    if (state_q == S_XFER) begin
      Output_valid         = Input_valid[grant_q];
      Input_ready[grant_q] = Output_ready;
    end
  end

  assign Grant_index = grant_q;

endmodule

// File: tb/tb_gmii_wrr_arb.sv
// Bench for gmii_wrr_arb: a 4-input/gap-12 instance and a 2-input/gap-0
// instance, driven from frame queues and checked by a beat scoreboard.
`timescale 1ns/1ps
module tb_gmii_wrr_arb;

  localparam int N  = 4;
  localparam int G  = 12;
  localparam int WW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT A (4 inputs, gap 12) ----------------
  logic [N*8-1:0]  in_data;
  logic [N-1:0]    in_valid, in_last, in_ready;
  logic [N*WW-1:0] in_weight;
  logic [7:0]      out_data;
  logic            out_valid, out_last, out_ready;
  logic [1:0]      grant;

  gmii_wrr_arb #(.NUM_INPUTS(N), .INTERFRAME_GAP(G), .WEIGHT_WIDTH(WW)) u_dut (
    .Clk(clk), .Rst_n(rst_n),
    .Input_data(in_data), .Input_valid(in_valid), .Input_last(in_last),
    .Input_ready(in_ready), .Input_weight(in_weight),
    .Output_data(out_data), .Output_valid(out_valid), .Output_last(out_last),
    .Output_ready(out_ready), .Grant_index(grant)
  );

  // ---------------- DUT B (2 inputs, gap 0) ----------------
  logic [15:0] b_data;
  logic [1:0]  b_valid, b_last, b_ready;
  logic [7:0]  b_weight;
  logic [7:0]  bo_data;
  logic        bo_valid, bo_last;
  logic        bo_ready = 1'b1;
  logic [0:0]  b_grant;

  gmii_wrr_arb #(.NUM_INPUTS(2), .INTERFRAME_GAP(0), .WEIGHT_WIDTH(4)) u_dut_b (
    .Clk(clk), .Rst_n(rst_n),
    .Input_data(b_data), .Input_valid(b_valid), .Input_last(b_last),
    .Input_ready(b_ready), .Input_weight(b_weight),
    .Output_data(bo_data), .Output_valid(bo_valid), .Output_last(bo_last),
    .Output_ready(bo_ready), .Grant_index(b_grant)
  );

  // ---------------- scoreboard state ----------------
  logic [8:0]  src_q [N][$];
  logic [8:0]  bsrc_q[$];
  logic [10:0] exp_q[$];
  logic [9:0]  exp_b_q[$];
  int errors = 0;
  int checks = 0;
  int beats_seen = 0;
  bit gap_chk = 1'b0;
  bit w0_chk  = 1'b0;
  bit rdy_mode = 1'b0;
  bit have_last = 1'b0, first_beat = 1'b1;
  int last_cyc = 0;
  bit have_last_b = 1'b0, first_beat_b = 1'b1;
  int last_cyc_b = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] fbyte(input int src, input int k, input logic [7:0] tag);
    return (k == 0) ? 8'(src) : tag + 8'(k);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_frame(input int src, input int len, input logic [7:0] tag);
    for (int k = 0; k < len; k++)
      src_q[src].push_back({(k == len - 1), fbyte(src, k, tag)});
  endtask

  // Expect the first 'upto' beats of a frame on DUT A from input 'src'.
  task automatic expect_frame(input int src, input int len, input logic [7:0] tag, input int upto);
    for (int k = 0; k < upto; k++)
      exp_q.push_back({2'(src), (k == len - 1), fbyte(src, k, tag)});
  endtask

  task automatic send_b_frame(input int len, input logic [7:0] tag);
    for (int k = 0; k < len; k++) begin
      bsrc_q.push_back({(k == len - 1), fbyte(0, k, tag)});
      exp_b_q.push_back({1'b0, (k == len - 1), fbyte(0, k, tag)});
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_b_out_valid", 32'(bo_valid), 32'd0);
    repeat (3) @(posedge clk);
    for (int i = 0; i < N; i++) src_q[i].delete();
    #2 rst_n = 1'b1;
    have_last  = 1'b0;
    first_beat = 1'b1;
  endtask

  task automatic wait_exp(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d beats outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (G + 4) @(posedge clk);
    #2;
  endtask

  // Present the head of each source queue; pop it after an accepted beat.
  logic [N-1:0] fire_v;
  logic         fire_b;
  initial begin : drv
    in_valid = '0; in_last = '0; in_data = '0;
    b_valid = '0; b_last = '0; b_data = '0;
    forever begin
      @(negedge clk);
      fire_v = in_valid & in_ready;
      fire_b = b_valid[0] & b_ready[0];
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (fire_v[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          in_valid[i] = 1'b1;
          in_last[i]  = src_q[i][0][8];
          in_data[i*8 +: 8] = src_q[i][0][7:0];
        end else begin
          in_valid[i] = 1'b0;
          in_last[i]  = 1'b0;
          in_data[i*8 +: 8] = 8'h00;
        end
      end
      if (fire_b && bsrc_q.size() > 0) void'(bsrc_q.pop_front());
      b_valid[0]  = (bsrc_q.size() > 0);
      b_last[0]   = (bsrc_q.size() > 0) ? bsrc_q[0][8] : 1'b0;
      b_data[7:0] = (bsrc_q.size() > 0) ? bsrc_q[0][7:0] : 8'h00;
    end
  end

  initial begin : rdy_drv
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = (rdy_mode == 1'b0) || (cyc % 16 == 0);
    end
  end

  // ---------------- monitors ----------------
  initial begin : mon_a
    logic [10:0] got, req;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        beats_seen++;
        got = {grant, out_last, out_data};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected_beat: got grant=%0d last=%0b data=%02h, expected no beat",
                   grant, out_last, out_data);
        end else begin
          req = exp_q.pop_front();
          check("a_beat{grant,last,data}", 32'(got), 32'(req));
        end
        if (gap_chk && first_beat && have_last)
          check("a_last_to_first_spacing", 32'(cyc - last_cyc), 32'(G + 2));
        first_beat = out_last;
        if (out_last) begin
          last_cyc  = cyc;
          have_last = 1'b1;
        end
      end
      if (rst_n && w0_chk) check("a_ready_disabled_input", 32'(in_ready[1]), 32'd0);
    end
  end

  initial begin : mon_b
    logic [9:0] got, req;
    forever begin
      @(negedge clk);
      if (rst_n && bo_valid && bo_ready) begin
        got = {b_grant, bo_last, bo_data};
        if (exp_b_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected_beat: got last=%0b data=%02h, expected no beat", bo_last, bo_data);
        end else begin
          req = exp_b_q.pop_front();
          check("b_beat{grant,last,data}", 32'(got), 32'(req));
        end
        if (first_beat_b && have_last_b)
          check("b_last_to_first_spacing", 32'(cyc - last_cyc_b), 32'd2);
        first_beat_b = bo_last;
        if (bo_last) begin
          last_cyc_b  = cyc;
          have_last_b = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin : main
    int i0, i1, base, n;
    in_weight = '0;
    b_weight  = '0;
    repeat (2) @(posedge clk);
    #2;

    // Equal weights on inputs 0/1: strict alternation with 14-cycle spacing.
    do_reset();
    in_weight = {4'd0, 4'd0, 4'd1, 4'd1};
    gap_chk = 1'b1;
    for (int f = 0; f < 4; f++) begin
      send_frame(0, 5, 8'(8'h10 * f));
      send_frame(1, 5, 8'(8'h80 + 8'h10 * f));
    end
    for (int f = 0; f < 4; f++) begin
      expect_frame(0, 5, 8'(8'h10 * f), 5);
      expect_frame(1, 5, 8'(8'h80 + 8'h10 * f), 5);
    end
    wait_exp(2000, "alternate");

    // Weights 3:1, both saturated: 0,0,0,1 repeating over 40 frames.
    do_reset();
    in_weight = {4'd0, 4'd0, 4'd1, 4'd3};
    for (int f = 0; f < 30; f++) send_frame(0, 3, 8'(f * 4));
    for (int f = 0; f < 10; f++) send_frame(1, 3, 8'(8'h40 + f * 4));
    i0 = 0; i1 = 0;
    for (int f = 0; f < 40; f++) begin
      if (f % 4 == 3) begin
        expect_frame(1, 3, 8'(8'h40 + i1 * 4), 3);
        i1++;
      end else begin
        expect_frame(0, 3, 8'(i0 * 4), 3);
        i0++;
      end
    end
    wait_exp(4000, "weighted_3_1");
    gap_chk = 1'b0;

    // Input 1 valid but weight 0: never granted until its weight is raised.
    do_reset();
    in_weight = {4'd0, 4'd0, 4'd0, 4'd1};
    w0_chk = 1'b1;
    for (int f = 0; f < 3; f++) send_frame(0, 4, 8'(8'h20 + f * 8));
    for (int f = 0; f < 2; f++) send_frame(1, 4, 8'(8'hA0 + f * 8));
    for (int f = 0; f < 3; f++) expect_frame(0, 4, 8'(8'h20 + f * 8), 4);
    wait_exp(2000, "weight0_blocked");
    w0_chk = 1'b0;
    in_weight = {4'd0, 4'd0, 4'd2, 4'd1};
    for (int f = 0; f < 2; f++) expect_frame(1, 4, 8'(8'hA0 + f * 8), 4);
    wait_exp(2000, "weight_raised");

    // Sparse Output_ready (1 in 16), four inputs, weights {2,1,1,1}.
    do_reset();
    in_weight = {4'd1, 4'd1, 4'd1, 4'd2};
    rdy_mode = 1'b1;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < ((i == 0) ? 6 : 3); k++)
        send_frame(i, 1 + ((i * 7 + k * 5) % 11), 8'(i * 64 + k * 8));
    for (int r = 0; r < 3; r++) begin
      expect_frame(0, 1 + ((r * 2 * 5) % 11), 8'(r * 2 * 8), 1 + ((r * 2 * 5) % 11));
      expect_frame(0, 1 + (((r * 2 + 1) * 5) % 11), 8'((r * 2 + 1) * 8),
                   1 + (((r * 2 + 1) * 5) % 11));
      for (int i = 1; i < N; i++)
        expect_frame(i, 1 + ((i * 7 + r * 5) % 11), 8'(i * 64 + r * 8),
                     1 + ((i * 7 + r * 5) % 11));
    end
    wait_exp(20000, "sparse_ready");
    rdy_mode = 1'b0;

    // Reset mid-frame: abort after three bytes, then a clean frame from input 0.
    do_reset();
    in_weight = {4'd0, 4'd0, 4'd0, 4'd1};
    base = beats_seen;
    send_frame(0, 10, 8'h30);
    expect_frame(0, 10, 8'h30, 3);
    n = 0;
    while (beats_seen < base + 3 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #2;
    check("midframe_byte3_valid", 32'(out_valid), 32'd1);
    check("midframe_byte3_data", 32'(out_data), 32'(fbyte(0, 3, 8'h30)));
    do_reset();
    check("after_reset_exp_empty", 32'(exp_q.size()), 32'd0);
    send_frame(0, 10, 8'h50);
    expect_frame(0, 10, 8'h50, 10);
    wait_exp(500, "after_reset_frame");

    // Gap 0 instance: back-to-back frames separated by one arbitration cycle.
    b_weight = {4'd1, 4'd1};
    for (int f = 0; f < 5; f++) send_b_frame(3, 8'(8'h60 + f * 8));
    n = 0;
    while (exp_b_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("b_drain_outstanding", 32'(exp_b_q.size()), 32'd0);
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
